// File: rtl/mvm_noc_pkg.sv
// Shared constants for the two-MVM NoC cluster: default lane geometry,
// signed saturation bounds per lane width, and the width of one buffered
// AXI-Stream beat {tlast, tuser, tdata}.
package mvm_noc_pkg;

  localparam int DEF_DATAW      = 32;
  localparam int DEF_OPRECISION = 8;
  localparam int DEF_LANES      = 4;
  localparam int DEF_DESTW      = 6;
  localparam int DEF_USERW      = 32;
  localparam int DEF_FIFOD      = 16;
  localparam int DEF_FIFOAW     = 4;

  // Largest value representable in a signed lane of 'prec' bits.
  function automatic int sat_max(input int prec);
    return (1 << (prec - 1)) - 1;
  endfunction

  // Smallest value representable in a signed lane of 'prec' bits.
  function automatic int sat_min(input int prec);
    return -(1 << (prec - 1));
  endfunction

  // One FIFO entry holds tdata, tuser and tlast.
  function automatic int entry_w(input int dataw, input int userw);
    return dataw + userw + 1;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO holding one AXI-Stream beat per entry.
// Ports: clk/rst_n (sync, active-low), push/push_dat in, pop in,
//        full/empty status, head_dat = oldest entry (valid when !empty).
// A write becomes visible at head_dat the cycle after the push.
module axis_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign head_dat = mem_q[rd_ptr_q];

  // A push into a full FIFO is still safe when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;   // wraps modulo DEPTH
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the occupancy counter defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/mvm_psum_reducer.sv
// Joins beat k of partial-sum stream A with beat k of stream B and adds them
// lane-by-lane (signed, saturating or wrapping) onto one AXI-Stream master.
// Ports: CLK/RST_N (sync, active-low); A_*, B_* slave streams; M_* master
//        stream; PKT_CNT counts accepted tlast beats; TLAST_ERR is sticky.
module mvm_psum_reducer
  import mvm_noc_pkg::*;
#(
  parameter int DATAW      = DEF_DATAW,
  parameter int OPRECISION = DEF_OPRECISION,
  parameter int LANES      = DEF_LANES,
  parameter int DESTW      = DEF_DESTW,
  parameter int USERW      = DEF_USERW,
  parameter int FIFOD      = DEF_FIFOD,
  parameter int FIFOAW     = DEF_FIFOAW,
  parameter int SATURATE   = 1,
  parameter int OUT_DEST   = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             A_TVALID,
  output logic             A_TREADY,
  input  logic [DATAW-1:0] A_TDATA,
  input  logic             A_TLAST,
  input  logic [USERW-1:0] A_TUSER,
  input  logic             B_TVALID,
  output logic             B_TREADY,
  input  logic [DATAW-1:0] B_TDATA,
  input  logic             B_TLAST,
  input  logic [USERW-1:0] B_TUSER,
  output logic             M_TVALID,
  input  logic             M_TREADY,
  output logic [DATAW-1:0] M_TDATA,
  output logic             M_TLAST,
  output logic [USERW-1:0] M_TUSER,
  output logic [DESTW-1:0] M_TDEST,
  output logic [15:0]      PKT_CNT,
  output logic             TLAST_ERR
);

  localparam int ENTW = entry_w(DATAW, USERW);
  localparam logic signed [OPRECISION:0] LANE_MAX = (OPRECISION+1)'(sat_max(OPRECISION));
  localparam logic signed [OPRECISION:0] LANE_MIN = (OPRECISION+1)'(sat_min(OPRECISION));

  logic            rdy_en_q, rdy_en_d;
  logic            a_full, a_empty, b_full, b_empty;
  logic [ENTW-1:0] a_head, b_head;
  logic            a_push, b_push, fire;

  logic [DATAW-1:0] a_dat, b_dat, sum_dat;
  logic [USERW-1:0] a_user, b_user;
  logic             a_last, b_last;

  logic             m_vld_q, m_vld_d;
  logic [DATAW-1:0] m_dat_q, m_dat_d;
  logic [USERW-1:0] m_user_q, m_user_d;
  logic             m_last_q, m_last_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;
  logic             err_q, err_d;

  logic signed [OPRECISION:0] lane_a, lane_b, lane_s;
  logic [OPRECISION-1:0]      lane_o;

  // Ready is held low through reset and for the reset cycle itself.
  assign A_TREADY = rdy_en_q && RST_N && !a_full;
  assign B_TREADY = rdy_en_q && RST_N && !b_full;
  assign a_push   = A_TVALID && A_TREADY;
  assign b_push   = B_TVALID && B_TREADY;

  axis_sync_fifo #(.WIDTH(ENTW), .DEPTH(FIFOD), .AW(FIFOAW)) u_fifo_a (
    .clk(CLK), .rst_n(RST_N), .push(a_push), .push_dat({A_TLAST, A_TUSER, A_TDATA}),
    .pop(fire), .full(a_full), .empty(a_empty), .head_dat(a_head)
  );

  axis_sync_fifo #(.WIDTH(ENTW), .DEPTH(FIFOD), .AW(FIFOAW)) u_fifo_b (
    .clk(CLK), .rst_n(RST_N), .push(b_push), .push_dat({B_TLAST, B_TUSER, B_TDATA}),
    .pop(fire), .full(b_full), .empty(b_empty), .head_dat(b_head)
  );

  assign a_dat  = a_head[DATAW-1:0];
  assign a_user = a_head[DATAW +: USERW];
  assign a_last = a_head[ENTW-1];
  assign b_dat  = b_head[DATAW-1:0];
  assign b_user = b_head[DATAW +: USERW];
  assign b_last = b_head[ENTW-1];

  // Both heads leave together, and only when the output slot is free or draining.
  assign fire = !a_empty && !b_empty && (!m_vld_q || M_TREADY);

  // Lane adders: one extra bit of headroom makes overflow detection a simple compare.
  always_comb begin
    sum_dat = '0;
    lane_a  = '0;
    lane_b  = '0;
    lane_s  = '0;
    lane_o  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_a = {a_dat[i*OPRECISION + OPRECISION-1], a_dat[i*OPRECISION +: OPRECISION]};
      lane_b = {b_dat[i*OPRECISION + OPRECISION-1], b_dat[i*OPRECISION +: OPRECISION]};
      lane_s = lane_a + lane_b;
      if (SATURATE != 0 && lane_s > LANE_MAX)      lane_o = LANE_MAX[OPRECISION-1:0];
      else if (SATURATE != 0 && lane_s < LANE_MIN) lane_o = LANE_MIN[OPRECISION-1:0];
      else                                         lane_o = lane_s[OPRECISION-1:0];
      sum_dat[i*OPRECISION +: OPRECISION] = lane_o;
    end
  end

  always_comb begin
    rdy_en_d  = 1'b1;
    m_vld_d   = m_vld_q;
    m_dat_d   = m_dat_q;
    m_user_d  = m_user_q;
    m_last_d  = m_last_q;
    pkt_cnt_d = pkt_cnt_q;
    err_d     = err_q;
    if (fire) begin
      m_vld_d  = 1'b1;
      m_dat_d  = sum_dat;
      m_user_d = a_user + b_user;
      m_last_d = a_last;
      if (a_last != b_last) err_d = 1'b1;
    end else if (M_TREADY) begin
      m_vld_d = 1'b0;
    end
    if (m_vld_q && M_TREADY && m_last_q) pkt_cnt_d = pkt_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rdy_en_q  <= 1'b0;
      m_vld_q   <= 1'b0;
      m_dat_q   <= '0;
      m_user_q  <= '0;
      m_last_q  <= 1'b0;
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rdy_en_q  <= rdy_en_d;
      m_vld_q   <= m_vld_d;
      m_dat_q   <= m_dat_d;
      m_user_q  <= m_user_d;
      m_last_q  <= m_last_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_q     <= err_d;
    end
  end

  assign M_TVALID  = m_vld_q;
  assign M_TDATA   = m_dat_q;
  assign M_TUSER   = m_user_q;
  assign M_TLAST   = m_last_q;
  assign M_TDEST   = DESTW'(OUT_DEST);
  assign PKT_CNT   = pkt_cnt_q;
  assign TLAST_ERR = err_q;

endmodule

// File: doc/mvm_psum_reducer.md
Name: mvm_psum_reducer

Overview:
- Downstream stage of the two-MVM NoC cluster. It consumes the two partial-result AXI-Stream outputs delivered by the cluster's egress router ports, one per MVM tile.
- Each input stream is buffered in its own FIFO. Beat k of stream A is joined with beat k of stream B, and the two are added lane-by-lane with signed saturation.
- The reduced vector is emitted on a single AXI-Stream master toward the host or next layer.
- Tracks packet count and flags framing mismatches between the two streams.

Parameters:
- DATAW, 32: tdata width; must equal LANES*OPRECISION.
- OPRECISION, 8: bits per signed lane.
- LANES, 4: lanes per beat.
- DESTW, 6: tdest width.
- USERW, 32: tuser width.
- FIFOD, 16: per-input FIFO depth; power of 2, at least 2.
- FIFOAW, 4: log2(FIFOD).
- SATURATE, 1: 1 = clamp each lane to the signed OPRECISION range; 0 = wrap modulo 2^OPRECISION.
- OUT_DEST, 0: constant driven on M_TDEST.

Ports:
- CLK  in  1  single clock.
- RST_N  in  1  reset, synchronous, active-low.
- A_TVALID  in  1  stream A valid.
- A_TREADY  out  1  stream A ready.
- A_TDATA  in  DATAW  stream A data.
- A_TLAST  in  1  stream A last.
- A_TUSER  in  USERW  stream A user.
- B_TVALID, B_TREADY, B_TDATA, B_TLAST, B_TUSER: same as the A_* ports, for stream B.
- M_TVALID  out  1  output valid.
- M_TREADY  in  1  output ready.
- M_TDATA  out  DATAW  reduced data.
- M_TLAST  out  1  output last.
- M_TUSER  out  USERW  A tuser + B tuser.
- M_TDEST  out  DESTW  equals OUT_DEST.
- PKT_CNT  out  16  count of output beats accepted with M_TLAST=1.
- TLAST_ERR  out  1  sticky framing-mismatch flag.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is synchronous and active-low; it is sampled on the CLK rising edge only.
- Reset values:
  - FIFOs are emptied.
  - A_TREADY=0 and B_TREADY=0 during reset; each rises in the first cycle after RST_N=1.
  - M_TVALID=0; M_TDATA, M_TLAST and M_TUSER are 0.
  - PKT_CNT=0 and TLAST_ERR=0.
  - Reset asserted mid-packet discards all buffered and in-flight beats. Nothing is emitted afterwards until new input arrives.
- Input FIFOs:
  - Each stores {tlast, tuser, tdata}.
  - X_TREADY = !full(X); a beat is written when X_TVALID && X_TREADY.
  - Full-throughput: simultaneous push and pop when full is allowed, but TREADY is still 0 while full (no lookahead).
  - The pointer wraps modulo FIFOD. Occupancy counter is FIFOAW+1 bits wide.
  - A write becomes visible at the FIFO head the following cycle.
- Join and advance:
  - fire = !emptyA && !emptyB && (!M_TVALID || M_TREADY).
  - On fire, both heads pop in the same cycle and the output register loads.
  - One empty FIFO means no pop from either; the other FIFO holds its data.
- Arithmetic, per lane i (bits [i*OPRECISION +: OPRECISION]):
  - Sign-extend both lanes to OPRECISION+1 bits and add.
  - With SATURATE=1, clamp to [-2^(OPRECISION-1), 2^(OPRECISION-1)-1]; for OPRECISION=8 that is [-128, 127].
  - With SATURATE=0, truncate to OPRECISION bits.
  - M_TUSER = A.tuser + B.tuser, modulo 2^USERW.
- M_TLAST = A.tlast of the joined beat.
- TLAST_ERR is set on a fire where A.tlast != B.tlast. It stays set until reset. Data still flows.
- Output register:
  - M_TVALID and the payload hold stable while M_TVALID && !M_TREADY.
  - M_TVALID falls after acceptance if no fire occurs in the same cycle.
  - Back-to-back beats at 1 per cycle are sustained while M_TREADY=1.
- Latency: the joining input handshake (the later of A and B) at cycle t gives M_TVALID=1 at cycle t+2.
- PKT_CNT increments on M_TVALID && M_TREADY && M_TLAST and wraps 0xFFFF -> 0.

Decomposition:
- Shared package, mvm_noc_pkg: lane-width constants, saturation bounds (SAT_MAX and SAT_MIN as functions of OPRECISION), and the FIFO entry width, DATAW+USERW+1.
- One sub-module: axis_sync_fifo (params WIDTH, DEPTH, AW; single clock; sync active-low reset; push/pop/full/empty/head). It is instantiated twice.
- Top RTL holds the join logic, the lane adders with clamp, the output register, and the counter/flag.

Test Plan:
- Single beat: A=0x01_02_03_04, B=0x10_20_30_40, both tlast=1, tuser 5 and 7, M_TREADY=1. Expect M_TDATA=0x11_22_33_44, M_TUSER=12, M_TLAST=1 two cycles after the handshakes, and PKT_CNT=1.
- Saturation: lanes 0x7F+0x01 -> 0x7F; 0x80+0xFF -> 0x80; 0x64+0x64 -> 0x7F. With SATURATE=0, 0x7F+0x01 -> 0x80.
- Skew and backpressure:
  - A sends 16 beats while B is idle: A_TREADY drops after 16 beats and no output appears.
  - B then sends 16 beats with M_TREADY toggling 1/0: all 16 sums emerge in order, payload is stable during stalls, and no beat is lost or duplicated.
- Throughput: continuous valid on both inputs and M_TREADY=1 for 64 beats. Expect one output per cycle after 2-cycle fill; tlast every 8th beat gives PKT_CNT=8.
- Framing error: A.tlast=1 with B.tlast=0 on a joined beat. TLAST_ERR rises the cycle after the fire and stays high for 20 more cycles of normal traffic.
- Reset mid-packet:
  - Assert RST_N=0 for 1 cycle with both FIFOs at 3 entries and M_TVALID=1.
  - Next cycle: M_TVALID=0, PKT_CNT=0, TLAST_ERR=0.
  - A fresh A/B pair then produces exactly one correct output.
